// File: rtl/cdb_pkg.sv
// Shared widths and round-robin helper for the common data bus arbiter.
// Latency: n/a (package). Backpressure: n/a.
// The pointer helper is kept here so the arbiter and any future CDB users agree on wrap rules.
package cdb_pkg;

   localparam int XLEN_DEF             = 64;
   localparam int ROB_INDEX_WIDTH_DEF  = 8;
   localparam int EXECUTION_LANES_DEF  = 3;
   localparam int LANE_INDEX_WIDTH_DEF = 2;

   // Pointer moves to the lane after the winner, wrapping past the last lane.
   function automatic int next_rr_ptr(input int g, input int lanes);
      return (g >= lanes - 1) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority select: first requester at or after rr_ptr, modulo LANES.
// Latency: purely combinational. Backpressure: none; the caller gates the grant.
// Pointer values >= LANES still produce an in-range index.
module rr_priority_select #(
   parameter int LANES = 3,
   parameter int IDX_W = 2
) (
   input  logic [LANES-1:0] request,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [LANES-1:0] grant,
   output logic [IDX_W-1:0] grant_index,
   output logic             any_grant
);

   int idx;

   always_comb begin
      grant       = '0;
      grant_index = '0;
      any_grant   = 1'b0;
      idx         = 0;
      for (int k = 0; k < LANES; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= LANES) idx = idx - LANES;
         if (!any_grant && request[idx]) begin
            any_grant   = 1'b1;
            grant[idx]  = 1'b1;
            grant_index = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin pick of one lane result into a one-entry broadcast stage.
// Latency: one cycle from lane acceptance to cdb_valid; one result per cycle when cdb_ready holds.
// Backpressure: a stalled broadcast (valid & ~cdb_ready) or a flush blocks every lane grant.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int XLEN             = XLEN_DEF,
   parameter int ROB_INDEX_WIDTH  = ROB_INDEX_WIDTH_DEF,
   parameter int EXECUTION_LANES  = EXECUTION_LANES_DEF,
   parameter int LANE_INDEX_WIDTH = LANE_INDEX_WIDTH_DEF
) (
   input  logic                                       clock,
   input  logic                                       reset,
   input  logic                                       flush,
   input  logic [EXECUTION_LANES-1:0]                 lane_valid,
   output logic [EXECUTION_LANES-1:0]                 lane_ready,
   input  logic [EXECUTION_LANES*ROB_INDEX_WIDTH-1:0] lane_ROB_index,
   input  logic [EXECUTION_LANES*XLEN-1:0]            lane_data,
   input  logic                                       cdb_ready,
   output logic                                       cdb_valid,
   output logic [ROB_INDEX_WIDTH-1:0]                 cdb_ROB_index,
   output logic [XLEN-1:0]                            cdb_data,
   output logic [LANE_INDEX_WIDTH-1:0]                cdb_lane
);

   typedef struct packed {
      logic [ROB_INDEX_WIDTH-1:0]  rob_index;
      logic [XLEN-1:0]             data;
      logic [LANE_INDEX_WIDTH-1:0] lane;
   } cdb_entry_t;

   logic [LANE_INDEX_WIDTH-1:0] rr_ptr;
   logic [EXECUTION_LANES-1:0]  grant_onehot;
   logic [LANE_INDEX_WIDTH-1:0] grant_index;
   logic                        any_grant;
   logic                        out_free;
   logic                        grant_en;
   logic                        cdb_valid_q;
   cdb_entry_t                  cdb_q;
   cdb_entry_t                  sel_entry;

   rr_priority_select #(
      .LANES (EXECUTION_LANES),
      .IDX_W (LANE_INDEX_WIDTH)
   ) u_select (
      .request     (lane_valid),
      .rr_ptr      (rr_ptr),
      .grant       (grant_onehot),
      .grant_index (grant_index),
      .any_grant   (any_grant)
   );

   assign out_free = ~cdb_valid_q | cdb_ready;
   // Reset gates the grant so no lane sees ready while reset is held.
   assign grant_en   = reset & out_free & ~flush & any_grant;
   assign lane_ready = {EXECUTION_LANES{grant_en}} & grant_onehot;

   always_comb begin
      sel_entry      = '0;
      sel_entry.lane = grant_index;
      for (int i = 0; i < EXECUTION_LANES; i++) begin
         sel_entry.rob_index = sel_entry.rob_index |
            ({ROB_INDEX_WIDTH{grant_onehot[i]}} & lane_ROB_index[i*ROB_INDEX_WIDTH +: ROB_INDEX_WIDTH]);
         sel_entry.data = sel_entry.data |
            ({XLEN{grant_onehot[i]}} & lane_data[i*XLEN +: XLEN]);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cdb_valid_q <= 1'b0;
         cdb_q       <= '0;
         rr_ptr      <= '0;
      end else if (flush) begin
         cdb_valid_q <= 1'b0;
      end else if (grant_en) begin
         cdb_valid_q <= 1'b1;
         cdb_q       <= sel_entry;
         rr_ptr      <= LANE_INDEX_WIDTH'(next_rr_ptr(int'(grant_index), EXECUTION_LANES));
      end else if (cdb_ready) begin
         // Drain: payload registers keep their last value.
         cdb_valid_q <= 1'b0;
      end
   end

   assign cdb_valid     = cdb_valid_q;
   assign cdb_ROB_index = cdb_q.rob_index;
   assign cdb_data      = cdb_q.data;
   assign cdb_lane      = cdb_q.lane;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table-driven bench for cdb_arbiter plus hand-written async-reset sequence.
module tb_cdb_arbiter;

   localparam logic [7:0]  T0 = 8'h0A, T1 = 8'h05, T2 = 8'h2C;
   localparam logic [63:0] D0 = 64'hA0A0, D1 = 64'hDEAD, D2 = 64'hC2C2;

   logic         clock = 1'b0;
   logic         reset;
   logic         flush;
   logic [2:0]   lane_valid;
   logic [2:0]   lane_ready;
   logic [23:0]  lane_ROB_index;
   logic [191:0] lane_data;
   logic         cdb_ready;
   logic         cdb_valid;
   logic [7:0]   cdb_ROB_index;
   logic [63:0]  cdb_data;
   logic [1:0]   cdb_lane;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   cdb_arbiter dut (
      .clock          (clock),
      .reset          (reset),
      .flush          (flush),
      .lane_valid     (lane_valid),
      .lane_ready     (lane_ready),
      .lane_ROB_index (lane_ROB_index),
      .lane_data      (lane_data),
      .cdb_ready      (cdb_ready),
      .cdb_valid      (cdb_valid),
      .cdb_ROB_index  (cdb_ROB_index),
      .cdb_data       (cdb_data),
      .cdb_lane       (cdb_lane)
   );

   typedef struct {
      logic        fl;
      logic [2:0]  lv;
      logic        rdy;
      logic [2:0]  exp_lr;
      logic        exp_v;
      logic [1:0]  exp_lane;
      logic [7:0]  exp_tag;
      logic [63:0] exp_data;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs[NV];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic fl, input logic [2:0] lv, input logic rdy,
                               input logic [2:0] lr, input logic v, input logic [1:0] ln,
                               input logic zero);
      vec_t r;
      r.fl = fl; r.lv = lv; r.rdy = rdy; r.exp_lr = lr; r.exp_v = v; r.exp_lane = ln;
      case (ln)
         2'd0:    begin r.exp_tag = T0; r.exp_data = D0; end
         2'd1:    begin r.exp_tag = T1; r.exp_data = D1; end
         default: begin r.exp_tag = T2; r.exp_data = D2; end
      endcase
      if (zero) begin r.exp_tag = '0; r.exp_data = '0; end
      return r;
   endfunction

   initial begin
      reset          = 1'b0;
      flush          = 1'b0;
      lane_valid     = '0;
      cdb_ready      = 1'b1;
      lane_ROB_index = {T2, T1, T0};
      lane_data      = {D2, D1, D0};

      //            fl  lv      rdy   exp_lr  v     lane  zero
      vecs[0]  = mk(0, 3'b000, 1, 3'b000, 0, 2'd0, 1);  // reset state
      vecs[1]  = mk(0, 3'b010, 1, 3'b010, 0, 2'd0, 1);  // single lane 1
      vecs[2]  = mk(0, 3'b000, 1, 3'b000, 1, 2'd1, 0);
      vecs[3]  = mk(0, 3'b000, 1, 3'b000, 0, 2'd1, 0);  // drained, payload held
      vecs[4]  = mk(0, 3'b111, 1, 3'b100, 0, 2'd1, 0);  // rr_ptr=2 after lane 1
      vecs[5]  = mk(0, 3'b111, 1, 3'b001, 1, 2'd2, 0);  // wrap to 0
      vecs[6]  = mk(0, 3'b111, 1, 3'b010, 1, 2'd0, 0);
      vecs[7]  = mk(0, 3'b111, 1, 3'b100, 1, 2'd1, 0);
      vecs[8]  = mk(0, 3'b111, 1, 3'b001, 1, 2'd2, 0);
      vecs[9]  = mk(0, 3'b111, 1, 3'b010, 1, 2'd0, 0);
      vecs[10] = mk(0, 3'b111, 1, 3'b100, 1, 2'd1, 0);
      vecs[11] = mk(0, 3'b111, 1, 3'b001, 1, 2'd2, 0);  // lane 0 accepted, rr_ptr=1
      vecs[12] = mk(0, 3'b101, 0, 3'b000, 1, 2'd0, 0);  // stall x4
      vecs[13] = mk(0, 3'b101, 0, 3'b000, 1, 2'd0, 0);
      vecs[14] = mk(0, 3'b101, 0, 3'b000, 1, 2'd0, 0);
      vecs[15] = mk(0, 3'b101, 0, 3'b000, 1, 2'd0, 0);
      vecs[16] = mk(0, 3'b101, 1, 3'b100, 1, 2'd0, 0);  // release: lane 2 (after rr_ptr=1)
      vecs[17] = mk(1, 3'b100, 0, 3'b000, 1, 2'd2, 0);  // flush while stalled
      vecs[18] = mk(0, 3'b100, 0, 3'b100, 0, 2'd2, 0);  // lane 2 right after flush
      vecs[19] = mk(1, 3'b011, 1, 3'b000, 1, 2'd2, 0);  // flush beats ready and grant
      vecs[20] = mk(1, 3'b011, 1, 3'b000, 0, 2'd2, 0);  // flush blocks grant on empty stage
      vecs[21] = mk(0, 3'b011, 1, 3'b001, 0, 2'd2, 0);  // rr_ptr still 0
      vecs[22] = mk(0, 3'b000, 1, 3'b000, 1, 2'd0, 0);
      vecs[23] = mk(0, 3'b000, 1, 3'b000, 0, 2'd0, 0);  // drained

      #12 reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(posedge clock);
         #1;
         flush      = vecs[i].fl;
         lane_valid = vecs[i].lv;
         cdb_ready  = vecs[i].rdy;
         #1;
         check($sformatf("v%0d lane_ready", i), 64'(lane_ready), 64'(vecs[i].exp_lr));
         check($sformatf("v%0d cdb_valid", i), 64'(cdb_valid), 64'(vecs[i].exp_v));
         check($sformatf("v%0d cdb_lane", i), 64'(cdb_lane), 64'(vecs[i].exp_lane));
         check($sformatf("v%0d cdb_tag", i), 64'(cdb_ROB_index), 64'(vecs[i].exp_tag));
         check($sformatf("v%0d cdb_data", i), cdb_data, vecs[i].exp_data);
      end

      // Async reset mid-stream; rr_ptr was 1, so lane 1 then lane 2 get in line.
      @(posedge clock);
      #1;
      flush      = 1'b0;
      cdb_ready  = 1'b1;
      lane_valid = 3'b111;
      #1;
      check("ar pre lane_ready", 64'(lane_ready), 64'(3'b010));
      @(posedge clock);
      #1;
      check("ar pre cdb_valid", 64'(cdb_valid), 64'd1);
      check("ar pre cdb_lane", 64'(cdb_lane), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      check("ar cdb_valid", 64'(cdb_valid), 64'd0);
      check("ar lane_ready", 64'(lane_ready), 64'd0);
      check("ar cdb_tag", 64'(cdb_ROB_index), 64'd0);
      check("ar cdb_data", cdb_data, 64'd0);
      check("ar cdb_lane", 64'(cdb_lane), 64'd0);
      @(posedge clock);
      #1;
      check("ar held lane_ready", 64'(lane_ready), 64'd0);
      check("ar held cdb_valid", 64'(cdb_valid), 64'd0);
      #3;
      reset      = 1'b1;
      lane_valid = 3'b110;
      #1;
      check("ar post lane_ready", 64'(lane_ready), 64'(3'b010));
      @(posedge clock);
      #1;
      lane_valid = 3'b000;
      #1;
      check("ar post cdb_valid", 64'(cdb_valid), 64'd1);
      check("ar post cdb_lane", 64'(cdb_lane), 64'd1);
      check("ar post cdb_tag", 64'(cdb_ROB_index), 64'(T1));
      check("ar post cdb_data", cdb_data, D1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
